// File: rtl/ps2_host_rx.sv
// PS/2 device-to-host frame receiver: synchronizes and filters the PS/2 lines, decodes
// 11-bit frames, checks odd parity and stop bit, and queues good bytes in a show-ahead FIFO.
module ps2_host_rx #(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 20000,
    parameter int DEPTH   = 4
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     ps2_clk_in,
    input  logic                     ps2_data_in,
    input  logic                     rd_en,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     overflow,
    output logic [1:0]               state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FILTER);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Index 0 is the clock line, index 1 the data line.
    logic [1:0]    clk_sync, data_sync;
    logic [1:0]    sync_now;
    logic [1:0]    filt;
    logic [FW-1:0] filt_cnt [2];
    logic          clk_f_d;
    logic          fall;

    state_t        state, state_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          par_q, par_n;
    logic [TW-1:0] tmo_cnt, tmo_n;
    logic          perr_n, ferr_n, frame_ok;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, push, pop, ovf_n;

    assign sync_now = {data_sync[1], clk_sync[1]};

    // A filtered line only follows the synchronized line after FILTER consecutive
    // disagreeing samples; any agreeing sample restarts the run.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            filt      <= 2'b11;
            for (int i = 0; i < 2; i++) filt_cnt[i] <= '0;
            clk_f_d   <= 1'b1;
            fall      <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            for (int i = 0; i < 2; i++) begin
                if (sync_now[i] == filt[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == FW'(FILTER - 1)) begin
                    filt[i]     <= sync_now[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 1'b1;
                end
            end
            clk_f_d <= filt[0];
            fall    <= clk_f_d & ~filt[0];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            bit_idx    <= '0;
            shreg      <= '0;
            par_q      <= 1'b0;
            tmo_cnt    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            par_q      <= par_n;
            tmo_cnt    <= tmo_n;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
            overflow   <= ovf_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        par_n     = par_q;
        tmo_n     = tmo_cnt;
        perr_n    = 1'b0;
        ferr_n    = 1'b0;
        frame_ok  = 1'b0;
        case (state)
            IDLE: begin
                tmo_n = '0;
                if (fall && !filt[1]) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shreg_n   = {filt[1], shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_n   = filt[1];
                    state_n = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_n = IDLE;
                    if (^{shreg, par_q} != 1'b1) perr_n   = 1'b1;
                    else if (!filt[1])           ferr_n   = 1'b1;
                    else                         frame_ok = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Mid-frame watchdog: a stalled clock abandons the partial frame.
        if (state != IDLE) begin
            if (fall) begin
                tmo_n = '0;
            end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                state_n  = IDLE;
                ferr_n   = 1'b1;
                frame_ok = 1'b0;
                tmo_n    = '0;
            end else begin
                tmo_n = tmo_cnt + 1'b1;
            end
        end
    end

    // Read side handshake: dout is valid whenever empty=0; rd_en high at a clock edge
    // with empty=0 consumes the head, rd_en while empty=1 has no effect.
    assign empty = (count == '0);
    assign full  = (count == (AW + 1)'(DEPTH));
    assign pop   = rd_en && !empty;
    assign push  = frame_ok && (!full || pop);
    assign ovf_n = frame_ok && full && !pop;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    assign dout      = empty ? 8'h00 : mem[rd_ptr];
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_ps2_host_rx.sv
// Bench for ps2_host_rx: drives PS/2 frames like hps_io and compares against a queue model
// of received bytes plus expected error-pulse counts.
module tb_ps2_host_rx;

    localparam int FILTER  = 4;
    localparam int TIMEOUT = 300;
    localparam int DEPTH   = 4;
    localparam int HALF    = 40;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk_in = 1'b1;
    logic       ps2_data_in = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] dout;
    logic       empty;
    logic [$clog2(DEPTH):0] count;
    logic       busy, parity_err, frame_err, overflow;
    logic [1:0] state_dbg;

    ps2_host_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT), .DEPTH(DEPTH)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .rd_en(rd_en), .dout(dout), .empty(empty), .count(count), .busy(busy),
        .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
    int obs_perr = 0, obs_ferr = 0, obs_ovf = 0;
    int last_ferr_cyc = 0;

    always @(negedge clk_sys) begin
        if (!reset) begin
            if (parity_err === 1'b1) obs_perr++;
            if (overflow === 1'b1)   obs_ovf++;
            if (frame_err === 1'b1) begin
                obs_ferr++;
                last_ferr_cyc = cyc;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic drive_bit(input logic b, output int low_cyc);
        tick(HALF / 2);
        ps2_data_in = b;
        tick(HALF / 2);
        ps2_clk_in = 1'b0;
        low_cyc = cyc;
        tick(HALF);
        ps2_clk_in = 1'b1;
    endtask

    task automatic verify_state(input string tag);
        @(negedge clk_sys);
        check_val({tag, "_count"}, count, exp_q.size());
        check_val({tag, "_empty"}, empty, exp_q.size() == 0);
        if (exp_q.size() > 0) check_val({tag, "_dout"}, dout, exp_q[0]);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_perr_cnt"}, obs_perr, exp_perr);
        check_val({tag, "_ferr_cnt"}, obs_ferr, exp_ferr);
        check_val({tag, "_ovf_cnt"}, obs_ovf, exp_ovf);
    endtask

    // Full frame; stop-bit fall cycle E is 7 edges after the clock line is driven low.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input bit pop_e);
        int lc;
        logic [9:0] bits;
        logic ok, ferr_now, ovf_now;
        bits = {par, b, 1'b0};
        for (int i = 0; i < 10; i++) drive_bit(bits[i], lc);
        tick(HALF / 2);
        ps2_data_in = stp;
        tick(HALF / 2);
        ps2_clk_in = 1'b0;
        tick(7);
        if (pop_e) rd_en = 1'b1;
        @(negedge clk_sys);
        check_val("stop_cycle_busy", busy, 1);
        check_val("stop_cycle_empty", empty, exp_q.size() == 0);
        if (pop_e && exp_q.size() > 0) begin
            check_val("pop_at_stop_dout", dout, exp_q[0]);
            void'(exp_q.pop_front());
        end
        ok       = (($countones(b) + int'(par)) % 2) == 1;
        ferr_now = ok && !stp;
        ovf_now  = ok && stp && (exp_q.size() >= DEPTH);
        if (!ok)          exp_perr++;
        else if (ferr_now) exp_ferr++;
        else if (ovf_now)  exp_ovf++;
        else               exp_q.push_back(b);
        @(posedge clk_sys);
        #1;
        rd_en = 1'b0;
        @(negedge clk_sys);
        check_val("e1_parity_err", parity_err, !ok);
        check_val("e1_frame_err", frame_err, ferr_now);
        check_val("e1_overflow", overflow, ovf_now);
        check_val("e1_busy", busy, 0);
        check_val("e1_count", count, exp_q.size());
        check_val("e1_empty", empty, exp_q.size() == 0);
        if (exp_q.size() > 0) check_val("e1_dout", dout, exp_q[0]);
        tick(HALF - 9);
        ps2_clk_in = 1'b1;
        ps2_data_in = 1'b1;
        tick(HALF);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, odd_par(b), 1'b1, 1'b0);
    endtask

    task automatic read_one();
        @(negedge clk_sys);
        check_val("read_empty", empty, exp_q.size() == 0);
        check_val("read_count", count, exp_q.size());
        if (exp_q.size() > 0) check_val("read_dout", dout, exp_q[0]);
        @(posedge clk_sys);
        #1;
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lc;
        logic [7:0] b;
        int mode;

        tick(3);
        @(negedge clk_sys);
        check_val("rst_empty", empty, 1);
        check_val("rst_count", count, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_dout", dout, 8'h00);
        check_val("rst_pulses", {parity_err, frame_err, overflow}, 3'b000);
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        tick(20);

        // good byte, then pop
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        read_one();
        verify_state("good");

        // parity error then recovery
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        verify_state("parity");
        read_one();

        // overflow and ordering
        for (int i = 1; i <= 5; i++) send_good(8'(i));
        verify_state("ovf");
        for (int i = 0; i < 4; i++) read_one();
        verify_state("ovf_drained");

        // push and pop together on a full FIFO, then on an empty one
        for (int i = 0; i < 4; i++) send_good(8'h11 + 8'(i));
        send_frame(8'h15, odd_par(8'h15), 1'b1, 1'b1);
        verify_state("full_pushpop");
        for (int i = 0; i < 4; i++) read_one();
        send_frame(8'h33, odd_par(8'h33), 1'b1, 1'b1);
        verify_state("empty_pushpop");
        read_one();

        // clock glitches shorter than the filter
        for (int w = 2; w <= FILTER - 1; w++) begin
            ps2_clk_in = 1'b0;
            tick(w);
            ps2_clk_in = 1'b1;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk_sys);
                check_val("glitch_busy", busy, 0);
            end
            verify_state("glitch");
        end

        // timeout after start + 4 data bits
        drive_bit(1'b0, lc);
        for (int i = 0; i < 4; i++) drive_bit(1'($urandom_range(0, 1)), lc);
        ps2_data_in = 1'b1;
        @(negedge clk_sys);
        check_val("tmo_busy_before", busy, 1);
        tick(TIMEOUT + 20);
        exp_ferr++;
        check_val("tmo_cycle", last_ferr_cyc, lc + TIMEOUT + 8);
        verify_state("timeout");
        send_good(8'h29);
        read_one();

        // reset mid-frame with two bytes queued; leftover bits are all ones
        send_good(8'h41);
        send_good(8'h42);
        drive_bit(1'b0, lc);
        drive_bit(1'b1, lc);
        drive_bit(1'b0, lc);
        drive_bit(1'b0, lc);
        @(negedge clk_sys);
        check_val("mid_busy", busy, 1);
        @(posedge clk_sys);
        #1;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk_sys);
        check_val("mrst_empty", empty, 1);
        check_val("mrst_count", count, 0);
        check_val("mrst_busy", busy, 0);
        for (int i = 0; i < 7; i++) drive_bit(1'b1, lc);
        tick(TIMEOUT + 20);
        verify_state("mid_reset");
        send_good(8'h76);
        verify_state("after_reset");
        read_one();

        // randomized frames and reads
        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom_range(0, 255));
            mode = $urandom_range(0, 5);
            case (mode)
                0:       send_frame(b, ~odd_par(b), 1'b1, $urandom_range(0, 3) == 0);
                1:       send_frame(b, odd_par(b), 1'b0, $urandom_range(0, 3) == 0);
                2:       send_frame(b, ~odd_par(b), 1'b0, $urandom_range(0, 3) == 0);
                default: send_frame(b, odd_par(b), 1'b1, $urandom_range(0, 3) == 0);
            endcase
            repeat ($urandom_range(0, 1)) read_one();
        end
        verify_state("random");
        while (exp_q.size() > 0) read_one();
        verify_state("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
